rr_mux_reg: RTL and testbench

Parametrised N-channel, W-bit registered selector with valid/ready handshake on every channel and on the output. It is the sequential successor to the MUX1_16x1 single-bit select tree. It supports two modes:
- explicit-select, where an external select port picks the channel;
- round-robin, where the block arbitrates among requesting channels itself.

It sits between multiple producers (register-file read ports, ALU result sources, memory return paths) and a single consumer.

---
 rtl/rr_mux_defs.sv | 22 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_mux_reg.sv | 103 ++++++++++
 tb/tb_rr_mux_reg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_defs.sv
`default_nettype none
// rr_mux_defs: mode encoding, default sizing and clog2 helper shared by rr_mux_reg and rr_pick.
// Rev 1.0
package rr_mux_defs;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int DEF_N_CH   = 16;
   localparam int DEF_DATA_W = 32;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// rr_pick: combinational rotating-priority encoder; first set request at or above i_ptr, modulo N_CH.
// Rev 1.0
module rr_pick
   import rr_mux_defs::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int SEL_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0]  i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_any
);

   localparam logic [SEL_W:0] C_N_CH = (SEL_W+1)'(N_CH);

   logic [2*N_CH-1:0] w_dbl;
   logic [N_CH-1:0]   w_rot;
   logic [SEL_W:0]    w_off;
   logic [SEL_W:0]    w_sum;

   // Doubling the request vector turns the wrap-around scan into a plain shift.
   assign w_dbl = {i_req, i_req};
   assign w_rot = N_CH'(w_dbl >> i_ptr);

   always_comb begin
      w_off = '0;
      o_any = 1'b0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off = (SEL_W+1)'(j);
            o_any = 1'b1;
         end
      end
   end

   assign w_sum = {1'b0, i_ptr} + w_off;
   assign o_idx = (w_sum >= C_N_CH) ? SEL_W'(w_sum - C_N_CH) : w_sum[SEL_W-1:0];

endmodule
`default_nettype wire

// File: rtl/rr_mux_reg.sv
`default_nettype none
// rr_mux_reg: N-channel registered selector, fixed-select or round-robin, valid/ready on every side.
// Rev 1.0
module rr_mux_reg
   import rr_mux_defs::*;
#(
   parameter  int N_CH   = DEF_N_CH,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int SEL_W  = clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH*DATA_W-1:0] i_data,
   input  logic [N_CH-1:0]        i_valid,
   output logic [N_CH-1:0]        o_ready,
   input  logic                   i_mode,
   input  logic [SEL_W-1:0]       i_sel,
   output logic [DATA_W-1:0]      o_data,
   output logic [SEL_W-1:0]       o_sel,
   output logic                   o_valid,
   input  logic                   i_ready
);

   localparam int               C_N_PAD = 1 << SEL_W;
   localparam logic [SEL_W-1:0] C_LAST  = SEL_W'(N_CH - 1);

   logic [C_N_PAD-1:0] w_valid_pad;
   logic [DATA_W-1:0]  w_ch [C_N_PAD];
   logic               w_ld;
   logic               w_fix_any;
   logic               w_rr_any;
   logic               w_gnt_any;
   logic               w_xfer;
   logic [SEL_W-1:0]   w_rr_idx;
   logic [SEL_W-1:0]   w_gnt_idx;
   logic [SEL_W-1:0]   w_ptr_nxt;
   logic [DATA_W-1:0]  w_data_sel;

   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [DATA_W-1:0]  r_data;
   logic               r_valid;

   // Padding to a power of two makes out-of-range selects read as "not valid".
   assign w_valid_pad = C_N_PAD'(i_valid);

   generate
      for (genvar i = 0; i < C_N_PAD; i++) begin : g_ch
         if (i < N_CH) begin : g_real
            assign w_ch[i] = i_data[i*DATA_W +: DATA_W];
         end else begin : g_pad
            assign w_ch[i] = '0;
         end
      end
   endgenerate

   rr_pick #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_pick (
      .i_req (i_valid),
      .i_ptr (r_ptr),
      .o_idx (w_rr_idx),
      .o_any (w_rr_any)
   );

   assign w_ld       = !r_valid || i_ready;
   assign w_fix_any  = w_valid_pad[i_sel];
   assign w_gnt_idx  = (i_mode == MODE_RR) ? w_rr_idx : i_sel;
   assign w_gnt_any  = (i_mode == MODE_RR) ? w_rr_any : w_fix_any;
   assign w_xfer     = w_gnt_any && w_ld;
   assign w_data_sel = w_ch[w_gnt_idx];
   assign w_ptr_nxt  = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;

   always_comb begin
      o_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_xfer && (w_gnt_idx == SEL_W'(i))) o_ready[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else if (w_ld) begin
         r_valid <= w_xfer;
         if (w_xfer) begin
            r_data <= w_data_sel;
            r_sel  <= w_gnt_idx;
            r_ptr  <= w_ptr_nxt;
         end
      end
   end

   assign o_data  = r_data;
   assign o_sel   = r_sel;
   assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
`default_nettype none
// tb_rr_mux_reg: directed self-checking bench; 16-channel instance plus a 12-channel instance for out-of-range selects.
// Rev 1.0
module tb_rr_mux_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [16*32-1:0] a_data;
   logic [15:0]      a_valid;
   logic [15:0]      a_rdy;
   logic             a_mode;
   logic [3:0]       a_sel;
   logic [31:0]      a_odata;
   logic [3:0]       a_osel;
   logic             a_ovalid;
   logic             a_iready;

   logic [12*32-1:0] b_data;
   logic [11:0]      b_valid;
   logic [11:0]      b_rdy;
   logic             b_mode;
   logic [3:0]       b_sel;
   logic [31:0]      b_odata;
   logic [3:0]       b_osel;
   logic             b_ovalid;
   logic             b_iready;

   int n_chk  = 0;
   int n_pass = 0;

   rr_mux_reg #(.N_CH(16), .DATA_W(32)) u_dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (a_data),
      .i_valid (a_valid),
      .o_ready (a_rdy),
      .i_mode  (a_mode),
      .i_sel   (a_sel),
      .o_data  (a_odata),
      .o_sel   (a_osel),
      .o_valid (a_ovalid),
      .i_ready (a_iready)
   );

   rr_mux_reg #(.N_CH(12), .DATA_W(32)) u_dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (b_data),
      .i_valid (b_valid),
      .o_ready (b_rdy),
      .i_mode  (b_mode),
      .i_sel   (b_sel),
      .o_data  (b_odata),
      .o_sel   (b_osel),
      .o_valid (b_ovalid),
      .i_ready (b_iready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int rr_exp [4] = '{2, 8, 2, 8};

   initial begin
      for (int i = 0; i < 16; i++) a_data[i*32 +: 32] = 32'hA0 + 32'(i);
      for (int i = 0; i < 12; i++) b_data[i*32 +: 32] = 32'hB0 + 32'(i);
      a_valid = '0; a_mode = 1'b0; a_sel = 4'd0; a_iready = 1'b1;
      b_valid = '0; b_mode = 1'b0; b_sel = 4'd0; b_iready = 1'b1;

      // reset state and combinational ready while held in reset
      #12;
      chk("rst_valid", a_ovalid, 0);
      chk("rst_data", a_odata, 0);
      chk("rst_sel", a_osel, 0);
      chk("rst_rdy_idle", a_rdy, 0);
      a_valid = 16'hFFFF;
      a_sel   = 4'd3;
      #1 chk("rst_rdy_fix", a_rdy, 16'h0008);
      @(posedge clk); #1 rst_n = 1'b1;

      // fixed-mode sweep
      for (int s = 0; s < 16; s++) begin
         a_sel = 4'(s);
         #1 chk("fix_rdy", a_rdy, 64'd1 << s);
         tick();
         chk("fix_data", a_odata, 32'hA0 + s);
         chk("fix_sel", a_osel, s);
         chk("fix_valid", a_ovalid, 1);
      end

      // round-robin from reset, all valid
      a_mode = 1'b1;
      rst_n  = 1'b0;
      #1 chk("rr_rst_valid", a_ovalid, 0);
      rst_n  = 1'b1;
      for (int k = 0; k < 18; k++) begin
         tick();
         chk("rr_sel", a_osel, k % 16);
         chk("rr_valid", a_ovalid, 1);
      end

      // round-robin, sparse requests on channels 2 and 8
      a_valid = 16'h0104;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("sparse_sel", a_osel, rr_exp[k]);
         chk("sparse_data", a_odata, 32'hA0 + rr_exp[k]);
      end

      // back-pressure after one beat from channel 5
      a_data[5*32 +: 32] = 32'hDEAD_BEEF;
      a_valid = 16'hFFFF;
      a_mode  = 1'b0;
      a_sel   = 4'd5;
      tick();
      chk("bp_data", a_odata, 32'hDEAD_BEEF);
      chk("bp_sel", a_osel, 5);
      a_iready = 1'b0;
      a_mode   = 1'b1;
      #1 chk("bp_rdy0", a_rdy, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold_data", a_odata, 32'hDEAD_BEEF);
         chk("bp_hold_valid", a_ovalid, 1);
         chk("bp_hold_rdy", a_rdy, 0);
      end
      a_iready = 1'b1;
      #1 chk("bp_release_rdy", a_rdy, 16'h0040);
      tick();
      chk("bp_next_sel", a_osel, 6);
      chk("bp_next_data", a_odata, 32'hA6);

      // asynchronous reset while a beat is held
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", a_ovalid, 0);
      chk("mid_rst_data", a_odata, 0);
      chk("mid_rst_rdy", a_rdy, 16'h0001);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
      chk("post_rst_sel", a_osel, 0);
      chk("post_rst_data", a_odata, 32'hA0);
      chk("post_rst_valid", a_ovalid, 1);

      // no requesters: ready low, beat drains, data/sel hold
      a_valid = '0;
      #1 chk("none_rdy", a_rdy, 0);
      tick();
      chk("none_valid", a_ovalid, 0);
      chk("none_data_hold", a_odata, 32'hA0);
      chk("none_sel_hold", a_osel, 0);
      a_mode  = 1'b0;
      a_sel   = 4'd9;
      a_valid = 16'hFDFF;
      #1 chk("fix_invalid_rdy", a_rdy, 0);

      // 12-channel instance: out-of-range select and pointer wrap
      b_valid = 12'hFFF;
      b_mode  = 1'b0;
      b_sel   = 4'hF;
      #1 chk("b_oor_rdy", b_rdy, 0);
      tick();
      chk("b_oor_valid", b_ovalid, 0);
      b_sel = 4'd11;
      #1 chk("b_last_rdy", b_rdy, 12'h800);
      tick();
      chk("b_last_data", b_odata, 32'hBB);
      chk("b_last_sel", b_osel, 11);
      chk("b_last_valid", b_ovalid, 1);
      b_mode = 1'b1;
      tick();
      chk("b_wrap_sel0", b_osel, 0);
      tick();
      chk("b_wrap_sel1", b_osel, 1);
      b_mode = 1'b0;
      b_sel  = 4'hC;
      #1 chk("b_oor12_rdy", b_rdy, 0);
      tick();
      chk("b_drain_valid", b_ovalid, 0);
      chk("b_drain_data", b_odata, 32'hB1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
